// File: rtl/lfsr_target_gen.sv
// ---------------------------------------------------------------------------
// lfsr_target_gen
//
// Pseudo-random target generator for the LED-catch game. A Galois LFSR is
// stepped once per prescaled tick; each new LFSR value is sliced into a
// (row, col) coordinate on a 2**COORD_W x 2**COORD_W LED matrix and offered
// to the matrix selection logic through a valid/ready handshake.
//
// Parameters
//   LFSR_W   LFSR width (8..32)
//   TAPS     Galois feedback mask, LFSR_W bits
//   SEED     reset / fallback seed, nonzero, LFSR_W bits
//   DIV      tick period in enabled clocks (>= 1)
//   COORD_W  coordinate width, 2*COORD_W <= LFSR_W
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   enable      advances prescaler / LFSR while high
//   seed_load   synchronous seed load strobe (highest priority after reset)
//   seed_in     seed value used by seed_load (zero selects SEED)
//   out_valid   a target is being presented
//   out_ready   consumer accepts the presented target
//   row, col    target coordinate
//   onehot_col  1 << col, column drive pattern
//   addr_base   row << COORD_W, matrix row base address
//   lfsr_state  current LFSR register (debug)
//
// Optional build macro
//   LFSR_TARGET_AVOID_REPEAT_EN  reject samples equal to the last
//                                transferred target (initially (0,0)).
// ---------------------------------------------------------------------------
module lfsr_target_gen #(
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                DIV     = 10,
  parameter int                COORD_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_W-1:0]     row,
  output logic [COORD_W-1:0]     col,
  output logic [2**COORD_W-1:0]  onehot_col,
  output logic [2*COORD_W-1:0]   addr_base,
  output logic [LFSR_W-1:0]      lfsr_state
);

  localparam int            MAT_N   = 2**COORD_W;
  localparam int            PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [PS_W-1:0]    prescaler_q, prescaler_d;
  logic               out_valid_q, out_valid_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;

  logic               tick;
  logic               xfer;
  logic               accept;
  logic               capture;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [COORD_W-1:0] samp_row;
  logic [COORD_W-1:0] samp_col;

`ifdef LFSR_TARGET_AVOID_REPEAT_EN
  logic [COORD_W-1:0] last_row_q, last_row_d;
  logic [COORD_W-1:0] last_col_q, last_col_d;
  logic [COORD_W-1:0] ref_row;
  logic [COORD_W-1:0] ref_col;
`endif

  // Tick, LFSR step and sample slicing
  always_comb begin
    tick      = enable && (prescaler_q == PS_LAST);
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    samp_col  = lfsr_next[COORD_W-1:0];
    samp_row  = lfsr_next[2*COORD_W-1:COORD_W];
    xfer      = out_valid_q && out_ready;
  end

`ifdef LFSR_TARGET_AVOID_REPEAT_EN
  // When a transfer happens on the same edge, the target leaving now becomes
  // the "last transferred" one, so the new sample is compared against it.
  always_comb begin
    ref_row = xfer ? row_q : last_row_q;
    ref_col = xfer ? col_q : last_col_q;
    accept  = !((samp_row == ref_row) && (samp_col == ref_col));
  end
`else
  always_comb begin
    accept = 1'b1;
  end
`endif

  // Capture only when the output slot is free or being emptied this edge;
  // otherwise the sample is dropped while the LFSR keeps stepping.
  always_comb begin
    capture = tick && (!out_valid_q || xfer) && accept;
  end

  // Next-state selection
  always_comb begin
    lfsr_d      = lfsr_q;
    prescaler_d = prescaler_q;
    out_valid_d = out_valid_q;
    row_d       = row_q;
    col_d       = col_q;
`ifdef LFSR_TARGET_AVOID_REPEAT_EN
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
`endif

    if (seed_load) begin
      // A zero seed would lock the LFSR up, so fall back to SEED.
      lfsr_d      = (seed_in == '0) ? SEED : seed_in;
      prescaler_d = '0;
      out_valid_d = 1'b0;
    end else begin
      if (enable) begin
        prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
      end
      if (tick) begin
        lfsr_d = lfsr_next;
      end
      if (capture) begin
        row_d       = samp_row;
        col_d       = samp_col;
        out_valid_d = 1'b1;
      end else if (xfer) begin
        out_valid_d = 1'b0;
      end
`ifdef LFSR_TARGET_AVOID_REPEAT_EN
      if (xfer) begin
        last_row_d = row_q;
        last_col_d = col_q;
      end
`endif
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q      <= SEED;
      prescaler_q <= '0;
      out_valid_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
`ifdef LFSR_TARGET_AVOID_REPEAT_EN
      last_row_q  <= '0;
      last_col_q  <= '0;
`endif
    end else begin
      lfsr_q      <= lfsr_d;
      prescaler_q <= prescaler_d;
      out_valid_q <= out_valid_d;
      row_q       <= row_d;
      col_q       <= col_d;
`ifdef LFSR_TARGET_AVOID_REPEAT_EN
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
`endif
    end
  end

  // Outputs; decoded forms come straight from the coordinate registers
  always_comb begin
    out_valid  = out_valid_q;
    row        = row_q;
    col        = col_q;
    lfsr_state = lfsr_q;
    onehot_col = MAT_N'(1) << col_q;
    addr_base  = {row_q, {COORD_W{1'b0}}};
  end

endmodule
